ln_rd_cmd_sched: RTL

Read-command scheduler for the LayerNorm stage-2 feature fetch. Walks the feature surface in the order the LN datapath consumes it (h outermost, then W burst, then channel group, beats innermost) and issues one memory read command per burst to the MCIF read port. It bounds outstanding bursts with a credit counter so the response FIFO in front of the LN controller can never overflow. It reports completion only after every issued burst has been fully returned.

---
 rtl/ln_rd_cmd_sched_pkg.sv | 20 ++
 rtl/ln_rd_addr_walker.sv | 128 ++++++++++++
 rtl/ln_rd_cmd_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ln_rd_cmd_sched_pkg.sv
// Shared definitions for the LayerNorm stage-2 read-command scheduler:
// FSM state encoding, burst sizing and outstanding-burst default.
package ln_rd_cmd_sched_pkg;

    localparam int LOG2_BURST_DEF = 4;
    localparam int MAX_OUT_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int burst_of(input int log2_burst);
        return 1 << log2_burst;
    endfunction

    localparam int BURST_DEF = burst_of(LOG2_BURST_DEF);

endpackage

// File: rtl/ln_rd_addr_walker.sv
// Nested channel / W-burst / row counters with incremental address
// accumulators; produces the registered command address and length.
module ln_rd_addr_walker
    import ln_rd_cmd_sched_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LOG2_BURST = LOG2_BURST_DEF,
    parameter int PIX_BYTES  = 64,
    parameter int CH_W       = 8,
    parameter int H_W        = 12,
    parameter int W_W        = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adv,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         line_stride,
    input  logic [AW-1:0]         surface_stride,
    input  logic [CH_W-1:0]       ch_num,
    input  logic [H_W-1:0]        h_num,
    input  logic [W_W-1:0]        w_num,
    output logic [AW-1:0]         addr,
    output logic [LOG2_BURST-1:0] len,
    output logic                  last
);

    localparam int            BURST   = burst_of(LOG2_BURST);
    localparam int            WB_W    = W_W - LOG2_BURST;
    localparam logic [AW-1:0] WB_STEP = AW'(BURST * PIX_BYTES);

    logic [CH_W-1:0]       ch_cnt, ch_n, ch_max;
    logic [WB_W-1:0]       wb_cnt, wb_n, wb_max, wb_max_sel;
    logic [H_W-1:0]        h_cnt, h_n, h_max;
    logic [LOG2_BURST-1:0] last_len, last_len_sel, len_q, len_n;
    logic [AW-1:0]         line_q, surf_q;
    logic [AW-1:0]         row_base, row_n, wb_base, wbb_n, cur_addr, addr_n;
    logic [W_W-1:0]        w_m1;
    logic                  ch_last, wb_last, h_last;

    assign w_m1    = w_num - 1'b1;
    assign ch_last = (ch_cnt == ch_max);
    assign wb_last = (wb_cnt == wb_max);
    assign h_last  = (h_cnt == h_max);
    assign last    = ch_last & wb_last & h_last;

    // A zero remainder wraps to all ones, which is exactly BURST-1.
    assign wb_max_sel   = load ? w_m1[W_W-1:LOG2_BURST] : wb_max;
    assign last_len_sel = load ? (w_num[LOG2_BURST-1:0] - 1'b1) : last_len;

    always_comb begin
        ch_n   = ch_cnt;
        wb_n   = wb_cnt;
        h_n    = h_cnt;
        row_n  = row_base;
        wbb_n  = wb_base;
        addr_n = cur_addr;
        if (load) begin
            ch_n   = '0;
            wb_n   = '0;
            h_n    = '0;
            row_n  = base_addr;
            wbb_n  = base_addr;
            addr_n = base_addr;
        end else if (adv) begin
            if (!ch_last) begin
                ch_n   = ch_cnt + 1'b1;
                addr_n = cur_addr + surf_q;
            end else begin
                ch_n = '0;
                if (!wb_last) begin
                    wb_n   = wb_cnt + 1'b1;
                    wbb_n  = wb_base + WB_STEP;
                    addr_n = wbb_n;
                end else begin
                    wb_n = '0;
                    if (!h_last) begin
                        h_n   = h_cnt + 1'b1;
                        row_n = row_base + line_q;
                    end else begin
                        h_n = '0;
                    end
                    wbb_n  = row_n;
                    addr_n = row_n;
                end
            end
        end
        len_n = (wb_n == wb_max_sel) ? last_len_sel : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt   <= '0;
            wb_cnt   <= '0;
            h_cnt    <= '0;
            ch_max   <= '0;
            wb_max   <= '0;
            h_max    <= '0;
            last_len <= '0;
            line_q   <= '0;
            surf_q   <= '0;
            row_base <= '0;
            wb_base  <= '0;
            cur_addr <= '0;
            len_q    <= '0;
        end else begin
            if (load) begin
                ch_max   <= ch_num - 1'b1;
                wb_max   <= w_m1[W_W-1:LOG2_BURST];
                h_max    <= h_num - 1'b1;
                last_len <= last_len_sel;
                line_q   <= line_stride;
                surf_q   <= surface_stride;
            end
            ch_cnt   <= ch_n;
            wb_cnt   <= wb_n;
            h_cnt    <= h_n;
            row_base <= row_n;
            wb_base  <= wbb_n;
            cur_addr <= addr_n;
            len_q    <= len_n;
        end
    end

    assign addr = cur_addr;
    assign len  = len_q;

endmodule

// File: rtl/ln_rd_cmd_sched.sv
// Read-command scheduler for LN stage-2 feature fetch: walks the surface,
// issues one read per burst and bounds outstanding bursts with credits.
module ln_rd_cmd_sched
    import ln_rd_cmd_sched_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LOG2_BURST = LOG2_BURST_DEF,
    parameter int PIX_BYTES  = 64,
    parameter int MAX_OUT    = MAX_OUT_DEF,
    parameter int CH_W       = 8,
    parameter int H_W        = 12,
    parameter int W_W        = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         line_stride,
    input  logic [AW-1:0]         surface_stride,
    input  logic [CH_W-1:0]       CH_in_div_Tout,
    input  logic [H_W-1:0]        h_in,
    input  logic [W_W-1:0]        w_in,
    output logic                  rd_req_vld,
    input  logic                  rd_req_rdy,
    output logic [AW-1:0]         rd_req_addr,
    output logic [LOG2_BURST-1:0] rd_req_len,
    input  logic                  burst_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err_underflow,
    output state_t                dbg_state
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    // rd_req handshake: a command transfers on any cycle where rd_req_vld and
    // rd_req_rdy are both high; once raised, vld and the command stay fixed
    // until that transfer happens.

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             vld_q, vld_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             accept, load, zero_cfg, walk_last, underflow;

    assign accept   = vld_q & rd_req_rdy;
    assign load     = start & (state_q == ST_IDLE);
    assign zero_cfg = (h_in == '0) | (w_in == '0) | (CH_in_div_Tout == '0);

    ln_rd_addr_walker #(
        .AW         (AW),
        .LOG2_BURST (LOG2_BURST),
        .PIX_BYTES  (PIX_BYTES),
        .CH_W       (CH_W),
        .H_W        (H_W),
        .W_W        (W_W)
    ) u_walker (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .adv            (accept),
        .base_addr      (base_addr),
        .line_stride    (line_stride),
        .surface_stride (surface_stride),
        .ch_num         (CH_in_div_Tout),
        .h_num          (h_in),
        .w_num          (w_in),
        .addr           (rd_req_addr),
        .len            (rd_req_len),
        .last           (walk_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_n = zero_cfg ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: if (accept && walk_last) state_n = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Credit counter: a simultaneous accept and burst_done cancel out.
    always_comb begin
        cnt_n     = cnt_q;
        underflow = 1'b0;
        case ({accept, burst_done})
            2'b10: cnt_n = cnt_q + 1'b1;
            2'b01: begin
                if (cnt_q == '0) underflow = 1'b1;
                else             cnt_n = cnt_q - 1'b1;
            end
            default: cnt_n = cnt_q;
        endcase
    end

    always_comb begin
        vld_d  = (state_n == ST_ISSUE) && (cnt_n < CNT_W'(MAX_OUT));
        busy_d = (state_n != ST_IDLE);
        done_d = (state_q == ST_DRAIN) && (cnt_q == '0);
        err_d  = (err_q & ~load) | underflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            vld_q  <= vld_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign rd_req_vld    = vld_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_underflow = err_q;
    assign dbg_state     = state_q;

endmodule
